// File: rtl/controller_pkg.sv
// Shared encodings for the controller action path: input codes, direction
// values and the action_filter FSM state constants.
package controller_pkg;

    localparam logic [2:0] CODE_UP    = 3'b000;
    localparam logic [2:0] CODE_DOWN  = 3'b001;
    localparam logic [2:0] CODE_RIGHT = 3'b010;
    localparam logic [2:0] CODE_LEFT  = 3'b011;
    localparam logic [2:0] CODE_PAUSE = 3'b100;
    localparam logic [2:0] CODE_NONE  = 3'b111;

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_DOWN  = 2'b01,
        DIR_RIGHT = 2'b10,
        DIR_LEFT  = 2'b11
    } dir_t;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_QUAL = 2'd1;
    localparam state_t ST_HELD = 2'd2;

endpackage

// File: rtl/code_debounce.sv
// Registers the raw action code and counts consecutive identical samples;
// qualify_pulse is a single-cycle strobe in the cycle after the qualifying sample.
module code_debounce
    import controller_pkg::*;
#(
    parameter int DEB_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] code_in,
    output logic [2:0] stable_code,
    output logic       qualify_pulse
);

    localparam logic [7:0] DEB_MAX = 8'(DEB_CYCLES);
    // Counter holds (samples - 1), so this value means the next matching sample is the last one needed.
    localparam logic [7:0] DEB_PRE = 8'(DEB_CYCLES - 2);

    logic [7:0] cnt;
    logic       same;

    assign same = (code_in == stable_code);

    always_ff @(posedge clk) begin
        if (rst) begin
            stable_code   <= CODE_NONE;
            cnt           <= '0;
            qualify_pulse <= 1'b0;
        end else begin
            stable_code   <= code_in;
            qualify_pulse <= same && (cnt == DEB_PRE);
            if (!same)
                cnt <= '0;
            else if (cnt != DEB_MAX)
                cnt <= cnt + 8'd1;
        end
    end

endmodule

// File: rtl/action_filter.sv
// Turns debounced action codes into direction commands with auto-repeat,
// reverse-direction rejection, pause toggling and a one-entry output buffer.
module action_filter
    import controller_pkg::*;
#(
    parameter int DEB_CYCLES    = 16,
    parameter int REPEAT_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] code_in,
    output logic       cmd_valid,
    output logic [1:0] cmd_dir,
    input  logic       cmd_ready,
    output logic       paused
);

    localparam logic [15:0] REP_LAST = 16'(REPEAT_CYCLES - 1);

    logic [2:0]  stable_code;
    logic        qualify_pulse;
    state_t      state;
    logic [15:0] rep_cnt;
    dir_t        last_dir;

    logic changed, is_dir, is_pause;
    logic qual_evt, rep_evt, dir_evt;
    logic reverse, accept, pause_toggle, pause_enter, hs;

    code_debounce #(
        .DEB_CYCLES(DEB_CYCLES)
    ) u_deb (
        .clk          (clk),
        .rst          (rst),
        .code_in      (code_in),
        .stable_code  (stable_code),
        .qualify_pulse(qualify_pulse)
    );

    assign changed  = (code_in != stable_code);
    assign is_dir   = ~stable_code[2];
    assign is_pause = (stable_code == CODE_PAUSE);

    // A qualification still counts even if the code moves on in the same cycle.
    assign qual_evt = (state == ST_QUAL) && qualify_pulse;
    assign rep_evt  = (state == ST_HELD) && !changed && (rep_cnt == REP_LAST);
    assign dir_evt  = is_dir && (qual_evt || rep_evt);

    assign reverse      = (stable_code[1] == last_dir[1]) && (stable_code[0] != last_dir[0]);
    assign accept       = dir_evt && !paused && !reverse;
    assign pause_toggle = qual_evt && is_pause;
    assign pause_enter  = pause_toggle && !paused;
    assign hs           = cmd_valid && cmd_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (changed) state <= ST_QUAL;
                ST_QUAL: begin
                    if (changed)
                        state <= ST_QUAL;
                    else if (qualify_pulse)
                        state <= ST_HELD;
                end
                ST_HELD: if (changed) state <= ST_QUAL;
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            rep_cnt <= '0;
        else if (qual_evt && !changed)
            rep_cnt <= '0;
        else if (state == ST_HELD)
            rep_cnt <= (rep_cnt == REP_LAST) ? 16'd0 : rep_cnt + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            paused <= 1'b0;
        else if (pause_toggle)
            paused <= ~paused;
    end

    // Pause entry wins over everything; a same-cycle handshake and new load keeps valid high.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_valid <= 1'b0;
            cmd_dir   <= DIR_RIGHT;
        end else if (pause_enter) begin
            cmd_valid <= 1'b0;
        end else if (accept) begin
            cmd_valid <= 1'b1;
            cmd_dir   <= stable_code[1:0];
        end else if (hs) begin
            cmd_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            last_dir <= DIR_RIGHT;
        else if (hs)
            last_dir <= dir_t'(cmd_dir);
    end

endmodule

// File: doc/action_filter.md
ACTION_FILTER -- requirements
Module: action_filter

Interface
REQ-001 The block SHALL have parameter DEB_CYCLES, default 16, number of consecutive identical samples that qualify a code (legal range 2..255).
REQ-002 The block SHALL have parameter REPEAT_CYCLES, default 1024, auto-repeat period for a held direction (legal range 2..65535).
REQ-003 clk  in  1  clock; all logic on its rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 code_in  in  3  action code from the controller stage: 000 up, 001 down, 010 right, 011 left, 100 pause, 101/110/111 none.
REQ-006 cmd_valid  out  1  a direction command is pending.
REQ-007 cmd_dir  out  2  pending direction: 00 up, 01 down, 10 right, 11 left.
REQ-008 cmd_ready  in  1  the consumer accepts the command in a cycle where cmd_valid and cmd_ready are both high.
REQ-009 paused  out  1  pause state, toggled by each qualified pause press.

Function
REQ-010 code_in SHALL be registered every cycle, and a stability counter SHALL increment while code_in equals the registered value and clear to 0 on any difference.
REQ-011 The code SHALL qualify on its DEB_CYCLES-th consecutive identical sample, and the resulting effect SHALL be visible in the following cycle.
REQ-012 The FSM SHALL have states IDLE (no qualified code), QUAL (counting), and HELD (qualified, same code still present).
REQ-013 Transitions: IDLE->QUAL on a code change; QUAL->HELD on qualification; QUAL/HELD->IDLE or QUAL on any code change (counter restarts).
REQ-014 A qualified none-code SHALL produce no event.
REQ-015 A qualified pause code SHALL toggle paused exactly once per press, with no repeat while held.
REQ-016 A qualified direction SHALL raise an event on entry to HELD, and again every REPEAT_CYCLES cycles while in HELD.
REQ-017 A direction whose bit1 equals last_dir bit1 and whose bit0 differs (i.e. the reverse of last_dir) SHALL be discarded.
REQ-018 last_dir SHALL update only on handshake completion.
REQ-019 Direction events SHALL be discarded while paused is high.
REQ-020 Entering pause SHALL clear any pending command (cmd_valid low the next cycle).
REQ-021 Output SHALL be a one-entry buffer: cmd_valid and cmd_dir stay stable until handshake; a new event while pending SHALL overwrite cmd_dir (latest wins) and keep cmd_valid high.
REQ-022 Handshake and a new event in the same cycle: the old command is consumed, the new one loads, and cmd_valid stays high.
REQ-023 The repeat counter SHALL be 16 bits, reset to 0 on entry to HELD, and wrap to 0 when it reaches REPEAT_CYCLES-1; the stability counter SHALL saturate at DEB_CYCLES.

Reset
REQ-024 While rst is high, at the next edge: state IDLE, counters 0, code register 111, cmd_valid 0, cmd_dir 10, last_dir 10 (right), paused 0.
REQ-025 Reset asserted mid-debounce or with a command pending SHALL discard all progress; no command SHALL survive reset.

Structure
REQ-026 Shared package controller_pkg SHALL hold the code constants (CODE_UP..CODE_NONE), the direction encoding typedef, and the FSM state typedef.
REQ-027 The debounce register/counter SHALL be sub-module code_debounce, outputs stable_code[2:0] and qualify_pulse.
REQ-028 The FSM, repeat timer, reverse filter, and output buffer SHALL reside in action_filter.

Verification (DEB_CYCLES=4, REPEAT_CYCLES=8)
REQ-029 code_in=000 from edge 1, cmd_ready=1 -> cmd_valid high exactly one cycle after edge 4, cmd_dir=00, second pulse 8 cycles later.
REQ-030 code_in toggles 000/111 every 3 cycles for 40 cycles -> cmd_valid never asserts.
REQ-031 last_dir=10, code_in=011 held 20 cycles -> no cmd_valid; then code_in=000 -> command 00 accepted.
REQ-032 cmd_ready=0, qualify 000 then 010 -> cmd_valid stays high, cmd_dir=10; raising cmd_ready -> single handshake, last_dir=10.
REQ-033 code_in=100 held 30 cycles -> paused=1 once; release and press again -> paused=0; direction presses while paused -> no cmd_valid.
REQ-034 rst pulsed for 1 cycle at count 3 of 4 -> all outputs at reset values; the same code then needs 4 new samples.
